// File: rtl/dino_jump_ctrl.sv
// Jump/physics controller for the dinosaur runner: owns the game state and
// integrates a signed vertical velocity under constant gravity on a divided tick.
module dino_jump_ctrl #(
   parameter int HEIGHT_W    = 6,
   parameter int MAX_HEIGHT  = 63,
   parameter int JUMP_VEL    = 5,
   parameter int GRAVITY     = 1,
   parameter int TICK_DIV    = 1,
   parameter int DOUBLE_JUMP = 0
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                button_jump,
   input  logic                collision,
   output logic [HEIGHT_W-1:0] dinosaur_height,
   output logic                game_status,
   output logic                airborne,
   output logic                game_over
);

   localparam int VW    = HEIGHT_W + 2;
   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic signed [VW-1:0] ZERO_S = '0;
   localparam logic signed [VW-1:0] MAX_S  = VW'(MAX_HEIGHT);
   localparam logic signed [VW-1:0] JUMP_S = VW'(JUMP_VEL);
   localparam logic signed [VW-1:0] GRAV_S = VW'(GRAVITY);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_AIR,
      S_OVER
   } state_t;

   state_t                state_q, state_d;
   logic [HEIGHT_W-1:0]   height_q, height_d;
   logic signed [VW-1:0]  vel_q, vel_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  btn_prev_q;
   logic                  extra_q, extra_d;
   logic                  status_q, air_q, over_q;

   logic                  press;
   logic                  tick;
   logic [CNT_W-1:0]      cnt_next;
   logic signed [VW-1:0]  nh;
   logic                  landing;

   assign press    = button_jump & ~btn_prev_q;
   assign tick     = (cnt_q == CNT_W'(TICK_DIV - 1));
   assign cnt_next = tick ? '0 : cnt_q + CNT_W'(1);
   assign nh       = $signed({2'b00, height_q}) + vel_q;
   assign landing  = tick && (nh <= ZERO_S);

   always_comb begin
      state_d  = state_q;
      height_d = height_q;
      vel_d    = vel_q;
      cnt_d    = cnt_q;
      extra_d  = extra_q;
      unique case (state_q)
         S_IDLE: begin
            if (press) begin
               state_d  = S_RUN;
               height_d = '0;
               vel_d    = '0;
               cnt_d    = '0;
               extra_d  = 1'b0;
            end
         end
         S_RUN: begin
            height_d = '0;
            vel_d    = '0;
            cnt_d    = cnt_next;
            if (collision) begin
               state_d = S_OVER;
            end else if (press) begin
               // Takeoff edge only loads velocity; the first height step waits for the next tick.
               state_d = S_AIR;
               vel_d   = JUMP_S;
            end
         end
         S_AIR: begin
            cnt_d = cnt_next;
            if (collision) begin
               state_d = S_OVER;
            end else if (landing) begin
               // Touching ground ends the airtime; a press on this same edge is dropped.
               state_d  = S_RUN;
               height_d = '0;
               vel_d    = '0;
               extra_d  = 1'b0;
            end else begin
               if (tick) begin
                  if (nh > MAX_S) begin
                     height_d = HEIGHT_W'(MAX_HEIGHT);
                     vel_d    = '0;
                  end else begin
                     height_d = nh[HEIGHT_W-1:0];
                     vel_d    = vel_q - GRAV_S;
                  end
               end
               if (press && (DOUBLE_JUMP != 0) && !extra_q) begin
                  vel_d   = JUMP_S;
                  extra_d = 1'b1;
               end
            end
         end
         S_OVER: begin
            if (press) begin
               state_d  = S_RUN;
               height_d = '0;
               vel_d    = '0;
               cnt_d    = '0;
               extra_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_IDLE;
         height_q   <= '0;
         vel_q      <= '0;
         cnt_q      <= '0;
         btn_prev_q <= 1'b0;
         extra_q    <= 1'b0;
         status_q   <= 1'b0;
         air_q      <= 1'b0;
         over_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         height_q   <= height_d;
         vel_q      <= vel_d;
         cnt_q      <= cnt_d;
         btn_prev_q <= button_jump;
         extra_q    <= extra_d;
         status_q   <= (state_d == S_RUN) || (state_d == S_AIR);
         air_q      <= (state_d == S_AIR);
         over_q     <= (state_d == S_OVER);
      end
   end

   assign dinosaur_height = height_q;
   assign game_status     = status_q;
   assign airborne        = air_q;
   assign game_over       = over_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Bench for dino_jump_ctrl: four parameter variants driven side by side, each
// tracked by a plain-integer game model, plus directed arcs from known heights.
module tb_dino_jump_ctrl;

   localparam int NI     = 4;
   localparam int JUMP   = 5;
   localparam int GRAV   = 1;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_AIR  = 2;
   localparam int M_OVER = 3;

   // Variants: 0 defaults, 1 slow tick, 2 double jump, 3 low ceiling.
   int p_tick [NI] = '{1, 4, 1, 1};
   int p_max  [NI] = '{63, 63, 63, 10};
   int p_dj   [NI] = '{0, 0, 1, 0};

   logic                 CLK = 1'b0;
   logic                 RST = 1'b0;
   logic [NI-1:0]        btn = '0;
   logic [NI-1:0]        col = '0;
   logic [NI-1:0][5:0]   h_o;
   logic [NI-1:0]        st_o, air_o, over_o;

   always #5 CLK = ~CLK;

   dino_jump_ctrl u_a (
      .CLK(CLK), .RST(RST), .button_jump(btn[0]), .collision(col[0]),
      .dinosaur_height(h_o[0]), .game_status(st_o[0]), .airborne(air_o[0]), .game_over(over_o[0])
   );
   dino_jump_ctrl #(.TICK_DIV(4)) u_b (
      .CLK(CLK), .RST(RST), .button_jump(btn[1]), .collision(col[1]),
      .dinosaur_height(h_o[1]), .game_status(st_o[1]), .airborne(air_o[1]), .game_over(over_o[1])
   );
   dino_jump_ctrl #(.DOUBLE_JUMP(1)) u_c (
      .CLK(CLK), .RST(RST), .button_jump(btn[2]), .collision(col[2]),
      .dinosaur_height(h_o[2]), .game_status(st_o[2]), .airborne(air_o[2]), .game_over(over_o[2])
   );
   dino_jump_ctrl #(.MAX_HEIGHT(10)) u_d (
      .CLK(CLK), .RST(RST), .button_jump(btn[3]), .collision(col[3]),
      .dinosaur_height(h_o[3]), .game_status(st_o[3]), .airborne(air_o[3]), .game_over(over_o[3])
   );

   int n_vec = 0;
   int n_err = 0;

   int m_mode [NI];
   int m_h    [NI];
   int m_v    [NI];
   int m_cnt  [NI];
   int m_prev [NI];
   int m_extra[NI];

   int arc [11] = '{5, 9, 12, 14, 15, 15, 14, 12, 9, 5, 0};
   int cb  [16] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
   int ch  [16] = '{5, 9, 12, 17, 21, 24, 26, 27, 27, 26, 24, 21, 17, 12, 6, 0};
   int dh  [8]  = '{5, 9, 10, 10, 9, 7, 4, 0};

   typedef struct {
      bit b;
      bit c;
      int h;
      bit st;
      bit air;
      bit ovr;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(bit b, bit c, int h, bit st, bit air, bit ovr);
      vec_t r;
      r.b = b; r.c = c; r.h = h; r.st = st; r.air = air; r.ovr = ovr;
      tbl.push_back(r);
   endfunction

   task automatic chk(input int k, input string what, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL inst%0d %s: got %0d, expected %0d (t=%0t)", k, what, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         m_mode[k] = M_IDLE; m_h[k] = 0; m_v[k] = 0;
         m_cnt[k] = 0; m_prev[k] = 0; m_extra[k] = 0;
      end
   endtask

   // One clock edge of the game rules for variant k with inputs b, c.
   task automatic model_step(input int k, input bit b, input bit c);
      bit press, tick, landed;
      int nh, nv;
      press = b && (m_prev[k] == 0);
      m_prev[k] = b;
      tick = (m_cnt[k] == p_tick[k] - 1);
      landed = 0;
      case (m_mode[k])
         M_IDLE: if (press) begin
            m_mode[k] = M_RUN; m_h[k] = 0; m_v[k] = 0; m_cnt[k] = 0; m_extra[k] = 0;
         end
         M_RUN: begin
            m_cnt[k] = (m_cnt[k] + 1) % p_tick[k];
            if (c) m_mode[k] = M_OVER;
            else if (press) begin m_mode[k] = M_AIR; m_v[k] = JUMP; end
         end
         M_AIR: begin
            m_cnt[k] = (m_cnt[k] + 1) % p_tick[k];
            if (c) m_mode[k] = M_OVER;
            else begin
               nv = m_v[k];
               if (tick) begin
                  nh = m_h[k] + m_v[k];
                  if (nh <= 0) landed = 1;
                  else if (nh > p_max[k]) begin m_h[k] = p_max[k]; nv = 0; end
                  else begin m_h[k] = nh; nv = m_v[k] - GRAV; end
               end
               if (landed) begin
                  m_mode[k] = M_RUN; m_h[k] = 0; m_v[k] = 0; m_extra[k] = 0;
               end else begin
                  if (press && p_dj[k] != 0 && m_extra[k] == 0) begin nv = JUMP; m_extra[k] = 1; end
                  m_v[k] = nv;
               end
            end
         end
         default: if (press) begin
            m_mode[k] = M_RUN; m_h[k] = 0; m_v[k] = 0; m_cnt[k] = 0; m_extra[k] = 0;
         end
      endcase
   endtask

   task automatic check_all();
      for (int k = 0; k < NI; k++) begin
         chk(k, "height", int'(h_o[k]), m_h[k]);
         chk(k, "game_status", int'(st_o[k]), (m_mode[k] == M_RUN || m_mode[k] == M_AIR) ? 1 : 0);
         chk(k, "airborne", int'(air_o[k]), (m_mode[k] == M_AIR) ? 1 : 0);
         chk(k, "game_over", int'(over_o[k]), (m_mode[k] == M_OVER) ? 1 : 0);
      end
   endtask

   task automatic cycle();
      for (int k = 0; k < NI; k++) model_step(k, btn[k], col[k]);
      @(posedge CLK);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      RST = 1'b1;
      #2;
      model_reset();
      check_all();
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   initial begin
      // Start, then held button must give a single start and no jump.
      for (int i = 0; i < 10; i++) add(1, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0);
      // Full default arc.
      add(1, 0, 0, 1, 1, 0);
      for (int i = 0; i < 10; i++) add(0, 0, arc[i], 1, 1, 0);
      add(0, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0);
      // Collision at height 9, frozen for 20 cycles, restart, then collision+press in RUN.
      add(1, 0, 0, 1, 1, 0);
      add(0, 0, 5, 1, 1, 0);
      add(0, 0, 9, 1, 1, 0);
      add(0, 1, 9, 0, 0, 1);
      for (int i = 0; i < 20; i++) add(0, (i % 3) == 0, 9, 0, 0, 1);
      add(1, 0, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0);
      add(1, 1, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 1);

      #1;
      do_reset();

      foreach (tbl[i]) begin
         btn[0] = tbl[i].b;
         col[0] = tbl[i].c;
         cycle();
         chk(0, "tbl_height", int'(h_o[0]), tbl[i].h);
         chk(0, "tbl_status", int'(st_o[0]), int'(tbl[i].st));
         chk(0, "tbl_airborne", int'(air_o[0]), int'(tbl[i].air));
         chk(0, "tbl_game_over", int'(over_o[0]), int'(tbl[i].ovr));
         $display("vec %0d: btn=%0d col=%0d -> height=%0d status=%0d air=%0d over=%0d",
                  i, tbl[i].b, tbl[i].c, h_o[0], st_o[0], air_o[0], over_o[0]);
      end
      btn[0] = 1'b0;
      col[0] = 1'b0;

      // Reset while in OVER returns to IDLE.
      do_reset();
      chk(0, "rst_game_over", int'(over_o[0]), 0);
      chk(0, "rst_status", int'(st_o[0]), 0);

      // Divided tick: same arc, one step every 4 cycles; mid-arc press ignored.
      btn[1] = 1'b1; cycle();
      btn[1] = 1'b0; cycle();
      btn[1] = 1'b1; cycle();
      chk(1, "b_takeoff_air", int'(air_o[1]), 1);
      for (int j = 1; j <= 42; j++) begin
         btn[1] = (j == 8);
         cycle();
         chk(1, "b_height", int'(h_o[1]), (j < 2) ? 0 : arc[(j - 2) / 4]);
         chk(1, "b_airborne", int'(air_o[1]), (j < 42) ? 1 : 0);
      end
      btn[1] = 1'b0;

      // Double jump: reload at 12, third press ignored, available again next airtime.
      btn[2] = 1'b1; cycle();
      btn[2] = 1'b0; cycle();
      for (int r = 0; r < 2; r++) begin
         btn[2] = 1'b1; cycle();
         for (int i = 0; i < 16; i++) begin
            btn[2] = cb[i][0];
            cycle();
            chk(2, "c_height", int'(h_o[2]), ch[i]);
            chk(2, "c_airborne", int'(air_o[2]), (i < 15) ? 1 : 0);
         end
      end

      // Ceiling clamp at 10.
      btn[3] = 1'b1; cycle();
      btn[3] = 1'b0; cycle();
      btn[3] = 1'b1; cycle();
      for (int i = 0; i < 8; i++) begin
         btn[3] = 1'b0;
         cycle();
         chk(3, "d_height", int'(h_o[3]), dh[i]);
      end

      // Random play on all variants with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            for (int k = 0; k < NI; k++) begin
               if ($urandom_range(0, 3) == 0) btn[k] = ~btn[k];
               col[k] = ($urandom_range(0, 59) == 0);
            end
            cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dino_jump_ctrl.md
Name: dino_jump_ctrl

Overview:
Parametrised jump/physics controller for the dinosaur runner, the successor to the single-width jump/status register block. It owns the game state (idle, running, airborne, game over) and integrates a signed vertical velocity under constant gravity on a divided game tick. The resulting dinosaur height goes to the renderer; collision comes back from the obstacle/hit logic.

Parameters:
HEIGHT_W, 6, width of dinosaur_height.
MAX_HEIGHT, 63, ceiling clamp for height; must be ≤ 2^HEIGHT_W-1.
JUMP_VEL, 5, initial upward velocity loaded on takeoff, in height units per tick; must be ≥ 1.
GRAVITY, 1, velocity decrement per tick; must be ≥ 1.
TICK_DIV, 1, CLK cycles per physics tick; must be ≥ 1.
DOUBLE_JUMP, 0, 1 = one extra mid-air jump allowed per airtime.

Ports:
CLK  input  1  system clock, all state on posedge.
RST  input  1  reset, asynchronous, active-high.
button_jump  input  1  raw level from the debounced jump button.
collision  input  1  level; high = dinosaur hit an obstacle this cycle.
dinosaur_height  output  HEIGHT_W  current height above ground, 0 = on ground.
game_status  output  1  1 while in RUN or AIR.
airborne  output  1  1 while in AIR.
game_over  output  1  1 while in OVER.

Behaviour:
- Reset (async, RST=1): state IDLE; dinosaur_height=0, velocity=0, game_status=0, airborne=0, game_over=0, tick counter=0, btn_prev=0, extra-jump flag=0. All outputs are registered.
- Press = button_jump & ~btn_prev; btn_prev registers button_jump every cycle. A held button produces exactly one press.
- Tick: the counter runs 0..TICK_DIV-1 only in RUN/AIR and wraps to 0. tick=1 when count==TICK_DIV-1. The counter is cleared on every entry to RUN from IDLE or OVER.
- Velocity is signed, HEIGHT_W+2 bits. The next height is computed as signed HEIGHT_W+2: nh = height + velocity.
- IDLE: press -> RUN; game_status=1 on the same edge.
- RUN: height=0, velocity=0.
  - collision -> OVER (highest priority).
  - Otherwise press -> AIR with velocity=JUMP_VEL and height unchanged. No height update occurs on the takeoff edge, even if tick=1.
- AIR, on a tick:
  - nh ≤ 0: height=0, velocity=0, state -> RUN (landing).
  - nh > MAX_HEIGHT: height=MAX_HEIGHT, velocity=0.
  - Otherwise: height=nh, velocity=velocity-GRAVITY.
- AIR, no tick: height and velocity hold.
- AIR, press with DOUBLE_JUMP=1 and extra flag clear: velocity=JUMP_VEL and the flag is set. This takes priority over the tick velocity update on that edge. If a tick coincides, the height still updates using the old velocity.
- AIR, press otherwise: ignored.
- The extra-jump flag clears on landing and on restart.
- AIR, collision -> OVER (priority over tick, press and landing).
- OVER: height and velocity are frozen at their values when the collision occurred; game_status=0, game_over=1. collision is ignored.
  - press -> RUN with height=0, velocity=0, counter=0, flag=0 (restart).
- Simultaneous collision and press in RUN: collision wins; the press is consumed and does not start a jump.
- RST asserted mid-jump or in OVER returns to IDLE immediately.
- Output flags follow the state register: airborne = (state==AIR), game_over = (state==OVER).

Test Plan:
1. Reset/start: RST pulse -> height=0, all flags 0. One press -> game_status=1 next edge; button held 10 cycles -> still one start, no jump.
2. Jump arc, defaults, TICK_DIV=1: press in RUN -> airborne=1. Per cycle, height = 5,9,12,14,15,15,14,12,9,5,0, then airborne=0 and state RUN.
3. Tick divider: TICK_DIV=4, same jump -> height changes only every 4th cycle (same sequence). A press during the arc is ignored with DOUBLE_JUMP=0.
4. Ceiling clamp: MAX_HEIGHT=10, JUMP_VEL=5 -> heights 5,9,10 (clamped, velocity→0), 10,9,7,4,0.
5. Double jump: DOUBLE_JUMP=1, press at height 12 -> velocity reloads 5, next ticks 17,21,… A third press in the same airtime is ignored. After landing, a double jump is available again.
6. Collision/restart: collision at height 9 mid-arc -> game_over=1, game_status=0, height stays 9 for 20 cycles. Press -> RUN, height=0. collision+press in the same RUN cycle -> OVER, no jump. RST during OVER -> IDLE.
